alu_operand_loader: RTL and testbench
=====================================

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter n, default 4, operand width in bits (matches ALU operand width).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept a button level change (min 2).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sw  input  n  raw switch bank, sampled as operand/opcode source.
REQ-006 SHALL have port btn_next  input  1  raw, active-high, bouncing "advance" button.
REQ-007 SHALL have port btn_clear  input  1  raw, active-high, bouncing "clear" button.
REQ-008 SHALL have port a  output  n  registered operand A to ALU.
REQ-009 SHALL have port b  output  n  registered operand B to ALU.
REQ-010 SHALL have port op  output  3  registered ALU opcode.
REQ-011 SHALL have port state  output  2  current FSM state encoding.
REQ-012 SHALL have port valid  output  1  high while a, b, op form a complete operation.

Function
REQ-013 Each raw button SHALL pass a 2-flop synchronizer before any other logic.
REQ-014 Per button, debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break resets the count to 0.
REQ-015 A press event SHALL be a single-cycle pulse on the debounced 0->1 transition; release (1->0) SHALL generate no event; held button SHALL generate exactly one event.
REQ-016 Raw-to-event latency SHALL be between 2+DEBOUNCE_CYCLES and 4+DEBOUNCE_CYCLES cycles, fixed for a given implementation.
REQ-017 FSM states SHALL be S_A=0, S_B=1, S_OP=2, S_READY=3, exposed on state.
REQ-018 S_A + next event: a<=sw, go S_B.
REQ-019 S_B + next event: b<=sw, go S_OP.
REQ-020 S_OP + next event: op<=sw[2:0] (sw[n-1:3] ignored; if n<3, zero-extended), go S_READY, valid<=1 same edge.
REQ-021 S_READY + next event: valid<=0, go S_A; a, b, op SHALL hold values until overwritten.
REQ-022 Clear event in any state: a<=0, b<=0, op<=0, valid<=0, go S_A.
REQ-023 Clear and next events in the same cycle: clear SHALL win, next discarded.
REQ-024 Without events, all outputs SHALL hold; sw changes SHALL never affect outputs outside a capture edge.
REQ-025 valid SHALL equal (state==S_READY) in every cycle.

Reset
REQ-026 rst high SHALL immediately (asynchronously) force a=0, b=0, op=0, valid=0, state=S_A, synchronizer flops=0, debounced levels=0, debounce counters=0.
REQ-027 rst asserted mid-sequence or while a button is held SHALL discard partial captures; a button held through reset release SHALL yield one event after the full debounce latency.

Verification (DEBOUNCE_CYCLES=4 in sim)
REQ-028 rst pulse, then idle 20 cycles -> a=0, b=0, op=0, state=0, valid=0 throughout.
REQ-029 sw=15 next-press, sw=15 next-press, sw=0 next-press -> a=15, b=15, op=0, state=3, valid=1; next-press -> state=0, valid=0, a=15 held.
REQ-030 sw=8/5/3 sequence with btn_next toggling every cycle for 3 cycles before each stable press -> exactly one capture per stable press, final a=8, b=5, op=3.
REQ-031 btn_next held 50 cycles in S_A with sw=7 -> a=7, state=1, no further advance; change sw during hold -> a stays 7.
REQ-032 In S_OP with a=9, b=2, btn_clear and btn_next raised same cycle -> state=0, a=0, b=0, op=0, valid=0.
REQ-033 rst asserted mid-cycle while in S_B -> outputs zero before the next clk edge; after release, sequence restarts from S_A.

Source files
------------

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Loads ALU operands A and B and a 3-bit opcode from a switch
//            bank, one capture per debounced press of a "next" button. A
//            "clear" button zeroes everything and returns to the first step.
//            Each raw button passes a 2-flop synchronizer and a level
//            debouncer. A press event is the 0->1 edge of the debounced level.
// Ports    : clk       - system clock, all state on rising edge
//            rst       - asynchronous active-high reset
//            sw        - switch bank [n-1:0], operand/opcode source
//            btn_next  - raw bouncing "advance" button
//            btn_clear - raw bouncing "clear" button
//            a, b      - registered operands [n-1:0]
//            op        - registered opcode [2:0]
//            state     - current step (0=A, 1=B, 2=OP, 3=READY)
//            valid     - high while a, b, op form a complete operation
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader #(
  parameter int n               = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] sw,
  input  logic         btn_next,
  input  logic         btn_clear,
  output logic [n-1:0] a,
  output logic [n-1:0] b,
  output logic [2:0]   op,
  output logic [1:0]   state,
  output logic         valid
);

  // The counter runs 0 .. DEBOUNCE_CYCLES-1. The level flips on the cycle
  // the count would reach DEBOUNCE_CYCLES.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_READY = 2'd3
  } state_t;

  // Bit 0 is "next" and bit 1 is "clear".
  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {btn_clear, btn_next};

  // --------------------------------------------------------------------------
  // Per-button synchronizer, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < 2; i++) begin : g_btn
      logic          r_meta;
      logic          r_sync;
      logic          r_level;
      logic          r_level_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_meta    <= 1'b0;
          r_sync    <= 1'b0;
          r_level   <= 1'b0;
          r_level_d <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_meta    <= w_raw[i];
          r_sync    <= r_meta;
          r_level_d <= r_level;
          // Count consecutive cycles in which the synchronized input
          // disagrees with the accepted level. Any agreement restarts the run.
          if (r_sync != r_level) begin
            if (r_cnt == c_cnt_max) begin
              r_level <= r_sync;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      // This signal pulses for one cycle on the press edge only. A release
      // produces no event.
      assign w_press[i] = r_level & ~r_level_d;
    end
  endgenerate

  logic w_next_evt;
  logic w_clear_evt;

  assign w_next_evt  = w_press[0];
  assign w_clear_evt = w_press[1];

  // --------------------------------------------------------------------------
  // Opcode source. Switch bits above bit 2 are ignored. A narrower bank is
  // zero-extended.
  // --------------------------------------------------------------------------
  logic [2:0] w_sw_op;

  generate
    if (n >= 3) begin : g_op_wide
      assign w_sw_op = sw[2:0];
      if (n > 3) begin : g_op_drop
        logic w_unused_sw;
        assign w_unused_sw = ^sw[n-1:3];
      end
    end else begin : g_op_narrow
      assign w_sw_op = {{(3 - n){1'b0}}, sw};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  state_t       r_state;
  state_t       w_state_nxt;
  logic [n-1:0] r_a;
  logic [n-1:0] r_b;
  logic [2:0]   r_op;
  logic [n-1:0] w_a_nxt;
  logic [n-1:0] w_b_nxt;
  logic [2:0]   w_op_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    // Clear takes priority. A simultaneous "next" event is dropped.
    if (w_clear_evt) begin
      w_state_nxt = S_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = '0;
    end else if (w_next_evt) begin
      case (r_state)
        S_A: begin
          w_a_nxt     = sw;
          w_state_nxt = S_B;
        end
        S_B: begin
          w_b_nxt     = sw;
          w_state_nxt = S_OP;
        end
        S_OP: begin
          w_op_nxt    = w_sw_op;
          w_state_nxt = S_READY;
        end
        default: begin
          // Operands and opcode stay held until the next capture overwrites them.
          w_state_nxt = S_A;
        end
      endcase
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign op    = r_op;
  assign state = r_state;
  // valid is decoded from the registered state, so it changes on the same
  // edge that enters or leaves READY.
  assign valid = (r_state == S_READY);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Self-checking bench for alu_operand_loader. It uses directed
//            scenarios followed by random operations. The expected values
//            come from a press-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw = '0;
  logic         btn_next = 1'b0;
  logic         btn_clear = 1'b0;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [2:0]   op;
  logic [1:0]   state;
  logic         valid;

  int checks = 0;
  int errors = 0;
  int lat_ref = -1;

  // Reference model. The step counter advances once per accepted press.
  logic [N-1:0] m_a = '0;
  logic [N-1:0] m_b = '0;
  logic [2:0]   m_op = '0;
  int           m_st = 0;

  alu_operand_loader #(.n(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_clear(btn_clear),
    .a(a), .b(b), .op(op), .state(state), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // valid must track READY in every cycle.
  always @(negedge clk) begin
    if (!rst) chk("valid_vs_state", {31'd0, valid}, {31'd0, (state == 2'd3)});
  end

  task automatic m_next(input logic [N-1:0] v);
    case (m_st)
      0: m_a = v;
      1: m_b = v;
      2: m_op = v[2:0];
      default: ;
    endcase
    m_st = (m_st + 1) % 4;
  endtask

  task automatic m_clear();
    m_a = '0; m_b = '0; m_op = '0; m_st = 0;
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a"}, a, m_a);
    chk({tag, "_b"}, b, m_b);
    chk({tag, "_op"}, op, m_op);
    chk({tag, "_state"}, state, m_st);
    chk({tag, "_valid"}, valid, (m_st == 3));
  endtask

  // This task performs one stable "next" press with optional bounce. sw is
  // scrambled after the capture and through the release.
  task automatic press_next(input logic [N-1:0] v, input bit bounce, input int hold);
    logic [1:0] prev;
    int lat;
    lat = 0;
    @(negedge clk);
    sw = v;
    if (bounce) begin
      repeat (3) begin
        btn_next = 1'b1; tick(1);
        btn_next = 1'b0; tick(1);
      end
    end
    btn_next = 1'b1;
    prev = state;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (state != prev) begin
        lat = i;
        break;
      end
    end
    chk("next_event_seen", {31'd0, (lat != 0)}, 32'd1);
    if (lat != 0) begin
      chk("latency_range", {31'd0, (lat >= D + 2 && lat <= D + 4)}, 32'd1);
      if (lat_ref < 0) lat_ref = lat;
      else chk("latency_fixed", lat, lat_ref);
    end
    m_next(v);
    check_all("capture");
    repeat (hold) begin
      @(negedge clk);
      sw = N'($urandom);
    end
    btn_next = 1'b0;
    repeat (D + 6) begin
      @(negedge clk);
      sw = N'($urandom);
    end
    check_all("after_next");
  endtask

  task automatic press_clear(input bit with_next);
    @(negedge clk);
    btn_clear = 1'b1;
    btn_next  = with_next;
    tick(D + 8);
    btn_clear = 1'b0;
    btn_next  = 1'b0;
    tick(D + 6);
    m_clear();
    check_all(with_next ? "clear_and_next" : "clear");
  endtask

  task automatic glitch();
    @(negedge clk);
    btn_next = 1'b1;
    tick($urandom_range(1, D - 1));
    btn_next = 1'b0;
    tick(D + 6);
    check_all("glitch");
  endtask

  initial begin
    logic [N-1:0] v;
    // Reset and idle period
    tick(2);
    rst = 1'b0;
    check_all("reset");
    repeat (20) begin
      @(negedge clk);
      check_all("idle");
    end

    // Full capture sequence followed by wrap to A
    press_next(4'd15, 1'b0, 2);
    press_next(4'd15, 1'b0, 2);
    press_next(4'd0, 1'b0, 2);
    chk("seq_state_ready", state, 32'd3);
    chk("seq_valid", valid, 32'd1);
    press_next(4'd6, 1'b0, 2);
    chk("wrap_state", state, 32'd0);
    chk("wrap_a_held", a, 32'd15);

    // Bounce before each stable press
    press_next(4'd8, 1'b1, 2);
    press_next(4'd5, 1'b1, 2);
    press_next(4'd3, 1'b1, 2);
    chk("bounce_a", a, 32'd8);
    chk("bounce_b", b, 32'd5);
    chk("bounce_op", op, 32'd3);
    press_next(4'd1, 1'b0, 2);

    // Long hold advances once, and sw changes during the hold are ignored
    press_next(4'd7, 1'b0, 45);
    chk("hold_a", a, 32'd7);
    chk("hold_state", state, 32'd1);

    // Simultaneous clear and next while in OP
    press_clear(1'b0);
    press_next(4'd9, 1'b0, 1);
    press_next(4'd2, 1'b0, 1);
    chk("pre_clear_state", state, 32'd2);
    press_clear(1'b1);
    chk("both_a", a, 32'd0);
    chk("both_state", state, 32'd0);

    // Asynchronous reset while in B
    press_next(4'd13, 1'b0, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_a", a, 32'd0);
    chk("async_rst_state", state, 32'd0);
    chk("async_rst_valid", valid, 32'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    check_all("post_rst");

    // A button held through reset release yields exactly one event
    @(negedge clk);
    sw = 4'd11;
    btn_next = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(D + 8);
    m_next(4'd11);
    check_all("held_through_rst");
    tick(20);
    check_all("held_no_repeat");
    btn_next = 1'b0;
    tick(D + 6);

    // Random operations
    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      v = N'($urandom);
      if (r <= 5) press_next(v, 1'($urandom), $urandom_range(0, 10));
      else if (r == 6) press_clear(1'b0);
      else if (r == 7) press_clear(1'b1);
      else if (r == 8) glitch();
      else begin
        @(negedge clk);
        sw = v;
        tick(3);
        check_all("sw_only");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
